// File: rtl/controle_registradores.sv
// Register-code sequencer: expands a one-cycle command into X/Y/Z operation codes
// and an ALU select for the datapath, with busy/done/err handshake.
module controle_registradores #(
    parameter int CODE_W = 5,
    parameter int CNT_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [CNT_W-1:0]  amt,
    output logic [CODE_W-1:0] tx,
    output logic [CODE_W-1:0] ty,
    output logic [CODE_W-1:0] tz,
    output logic [1:0]        ula_sel,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CODE_W-1:0] C_CLEAR  = CODE_W'(0);
    localparam logic [CODE_W-1:0] C_LOAD   = CODE_W'(1);
    localparam logic [CODE_W-1:0] C_HOLD   = CODE_W'(2);
    localparam logic [CODE_W-1:0] C_SHIFTL = CODE_W'(3);

    localparam logic [2:0] OP_CLR  = 3'd0;
    localparam logic [2:0] OP_LDY  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_SHL  = 3'd4;
    localparam logic [2:0] OP_MOVE = 3'd5;

    localparam logic [1:0] U_PASS = 2'd0;
    localparam logic [1:0] U_ADD  = 2'd1;
    localparam logic [1:0] U_SUB  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [2:0]         r_op;
    logic [CNT_W-1:0]   r_amt, r_cnt, w_cnt;
    logic [CODE_W-1:0]  r_tx, r_ty, r_tz, w_tx, w_ty, w_tz;
    logic [1:0]         r_ula, w_ula;
    logic               r_busy, r_done, r_err, w_busy, w_done, w_err;
    logic               w_illegal, w_skip;

    assign w_illegal = (op > OP_MOVE);
    assign w_skip    = w_illegal || (op == OP_SHL && amt == '0);

    // r_cnt counts shift cycles already scheduled, so EXEC of SHL_Y is the first shift
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tx    <= C_HOLD;
            r_ty    <= C_HOLD;
            r_tz    <= C_HOLD;
            r_ula   <= U_PASS;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_tx    <= w_tx;
            r_ty    <= w_ty;
            r_tz    <= w_tz;
            r_ula   <= w_ula;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    always_ff @(posedge clock) begin
        if (r_state == S_IDLE && start) begin
            r_op  <= op;
            r_amt <= amt;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:          if (start) w_next = w_skip ? S_DONE : S_EXEC;
            S_EXEC, S_SHIFT: w_next = (r_op == OP_SHL && r_cnt < r_amt) ? S_SHIFT : S_DONE;
            S_DONE:          w_next = S_IDLE;
            default:         w_next = S_IDLE;
        endcase
    end

    // Outputs are the registered image of the cycle being entered
    always_comb begin
        w_tx   = C_HOLD;
        w_ty   = C_HOLD;
        w_tz   = C_HOLD;
        w_ula  = r_ula;
        w_done = 1'b0;
        w_err  = 1'b0;
        w_busy = (w_next != S_IDLE);
        w_cnt  = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                if (start) begin
                    if (w_skip) begin
                        w_done = 1'b1;
                        w_err  = w_illegal;
                    end else begin
                        unique case (op)
                            OP_CLR: begin
                                w_tx = C_CLEAR;
                                w_ty = C_CLEAR;
                                w_tz = C_CLEAR;
                            end
                            OP_LDY:  begin w_ty = C_LOAD; w_ula = U_PASS; end
                            OP_ADD:  begin w_ty = C_LOAD; w_ula = U_ADD;  end
                            OP_SUB:  begin w_ty = C_LOAD; w_ula = U_SUB;  end
                            OP_SHL:  begin w_ty = C_SHIFTL; w_cnt = CNT_W'(1); end
                            OP_MOVE: begin w_tz = C_LOAD; w_ula = U_PASS; end
                            default: w_ty = C_HOLD;
                        endcase
                    end
                end
            end
            S_EXEC, S_SHIFT: begin
                if (w_next == S_SHIFT) begin
                    w_ty  = C_SHIFTL;
                    w_cnt = r_cnt + CNT_W'(1);
                end else begin
                    w_done = 1'b1;
                end
            end
            S_DONE:  w_cnt = '0;
            default: w_cnt = '0;
        endcase
    end

    assign tx      = r_tx;
    assign ty      = r_ty;
    assign tz      = r_tz;
    assign ula_sel = r_ula;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_controle_registradores.sv
// Self-checking bench for controle_registradores: table of directed commands,
// hand-written reset/back-to-back sequences, and random commands against a model.
module tb_controle_registradores;

    logic       clock = 1'b0;
    logic       reset, start;
    logic [2:0] op, amt;
    logic [4:0] tx, ty, tz;
    logic [1:0] ula_sel;
    logic       busy, done, err;

    controle_registradores #(.CODE_W(5), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .amt(amt),
        .tx(tx), .ty(ty), .tz(tz), .ula_sel(ula_sel),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] op;
        logic [2:0] amt;
        logic [4:0] etx, ety, etz;
        logic [1:0] eula;
        int         ncode;
        logic       eerr;
    } vec_t;

    vec_t       tbl[11];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] m_ula = 2'd0;
    logic [19:0] q[$];
    wire  [19:0] w_got = {tx, ty, tz, ula_sel, busy, done, err};

    function automatic logic [19:0] mk(input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] c, input logic [1:0] u,
                                       input logic bz, input logic dn, input logic er);
        return {a, b, c, u, bz, dn, er};
    endfunction

    task automatic chk(input string nm, input logic [19:0] exp);
        n_cmp++;
        if (w_got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {tx,ty,tz,ula,busy,done,err}=%05h expected %05h at %0t",
                     nm, w_got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Expected per-cycle outputs of one command, from the command rules
    task automatic model(input logic [2:0] o, input logic [2:0] a);
        logic [4:0] x, y, z;
        q.delete();
        x = 5'd2; y = 5'd2; z = 5'd2;
        if (o > 3'd5) begin
            q.push_back(mk(2, 2, 2, m_ula, 1, 1, 1));
            return;
        end
        if (o == 3'd4) begin
            for (int i = 0; i < int'(a); i++) q.push_back(mk(2, 3, 2, m_ula, 1, 0, 0));
        end else begin
            case (o)
                3'd0: begin x = 0; y = 0; z = 0; end
                3'd1: begin y = 1; m_ula = 0; end
                3'd2: begin y = 1; m_ula = 1; end
                3'd3: begin y = 1; m_ula = 2; end
                default: begin z = 1; m_ula = 0; end
            endcase
            q.push_back(mk(x, y, z, m_ula, 1, 0, 0));
        end
        q.push_back(mk(2, 2, 2, m_ula, 1, 1, 0));
    endtask

    // Entered and left at a negedge; the trailing cycle is the first IDLE cycle
    task automatic run_cmd(input logic [2:0] o, input logic [2:0] a, input bit noise);
        model(o, a);
        start = 1'b1; op = o; amt = a;
        step();
        start = 1'b0;
        foreach (q[i]) begin
            chk("cmd_cycle", q[i]);
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                op    = 3'($urandom_range(0, 7));
                amt   = 3'($urandom_range(0, 7));
            end
            step();
        end
        start = 1'b0;
        chk("post_idle", mk(2, 2, 2, m_ula, 0, 0, 0));
    endtask

    initial begin
        tbl[0]  = '{3'd2, 3'd0, 5'd2, 5'd1, 5'd2, 2'd1, 1, 1'b0};
        tbl[1]  = '{3'd4, 3'd5, 5'd2, 5'd3, 5'd2, 2'd1, 5, 1'b0};
        tbl[2]  = '{3'd4, 3'd0, 5'd2, 5'd2, 5'd2, 2'd1, 0, 1'b0};
        tbl[3]  = '{3'd4, 3'd7, 5'd2, 5'd3, 5'd2, 2'd1, 7, 1'b0};
        tbl[4]  = '{3'd6, 3'd3, 5'd2, 5'd2, 5'd2, 2'd1, 0, 1'b1};
        tbl[5]  = '{3'd3, 3'd0, 5'd2, 5'd1, 5'd2, 2'd2, 1, 1'b0};
        tbl[6]  = '{3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 2'd2, 1, 1'b0};
        tbl[7]  = '{3'd1, 3'd0, 5'd2, 5'd1, 5'd2, 2'd0, 1, 1'b0};
        tbl[8]  = '{3'd5, 3'd0, 5'd2, 5'd2, 5'd1, 2'd0, 1, 1'b0};
        tbl[9]  = '{3'd7, 3'd0, 5'd2, 5'd2, 5'd2, 2'd0, 0, 1'b1};
        tbl[10] = '{3'd4, 3'd1, 5'd2, 5'd3, 5'd2, 2'd0, 1, 1'b0};

        reset = 1'b1; start = 1'b0; op = 3'd0; amt = 3'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset_state", mk(2, 2, 2, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle", mk(2, 2, 2, 0, 0, 0, 0));
        end

        for (int i = 0; i < 11; i++) begin
            start = 1'b1; op = tbl[i].op; amt = tbl[i].amt;
            step();
            start = 1'b0;
            for (int c = 0; c < tbl[i].ncode; c++) begin
                chk("tbl_code", mk(tbl[i].etx, tbl[i].ety, tbl[i].etz, tbl[i].eula, 1, 0, 0));
                step();
            end
            chk("tbl_done", mk(2, 2, 2, tbl[i].eula, 1, 1, tbl[i].eerr));
            step();
            chk("tbl_idle", mk(2, 2, 2, tbl[i].eula, 0, 0, 0));
            m_ula = tbl[i].eula;
            step();
        end

        // start pulses while busy are dropped; the first IDLE cycle accepts a command
        run_cmd(3'd4, 3'd4, 1'b1);
        run_cmd(3'd2, 3'd0, 1'b0);

        // reset on the 2nd shift abandons the command without done
        start = 1'b1; op = 3'd4; amt = 3'd6;
        step();
        start = 1'b0;
        chk("rst_shift1", mk(2, 3, 2, m_ula, 1, 0, 0));
        step();
        chk("rst_shift2", mk(2, 3, 2, m_ula, 1, 0, 0));
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_ula = 2'd0;
        chk("rst_abort", mk(2, 2, 2, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rst_no_done", mk(2, 2, 2, 0, 0, 0, 0));
        end
        run_cmd(3'd0, 3'd0, 1'b0);

        // reset together with start: start is dropped
        run_cmd(3'd2, 3'd0, 1'b0);
        reset = 1'b1; start = 1'b1; op = 3'd3; amt = 3'd0;
        step();
        reset = 1'b0; start = 1'b0;
        m_ula = 2'd0;
        chk("rst_start", mk(2, 2, 2, 0, 0, 0, 0));
        step();
        chk("rst_start_idle", mk(2, 2, 2, 0, 0, 0, 0));

        for (int n = 0; n < 200; n++) begin
            run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                op = 3'($urandom_range(0, 7));
                step();
                chk("rand_gap", mk(2, 2, 2, m_ula, 0, 0, 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
